// File: rtl/dma_cmd_arbiter_pkg.sv
// Shared types for the two-requester DMA command arbiter: command and FSM
// state encodings plus the per-requester command record.
package dma_arb_pkg;

  localparam int NUM_REQ = 2;

  typedef enum logic [1:0] {
    CMD_READ   = 2'b00,
    CMD_WRITE  = 2'b01,
    CMD_SWITCH = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LAUNCH    = 3'd1,
    ST_WAIT_BUSY = 3'd2,
    ST_WAIT_IDLE = 3'd3,
    ST_DONE      = 3'd4
  } arb_state_e;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [31:0] address;
    logic [7:0]  burst_size;
    logic [7:0]  block_size;
    logic [3:0]  byte_enable;
  } dma_req_t;

endpackage

// File: rtl/dma_cmd_arbiter_if.sv
// Requester and DMA-engine signals of the command arbiter. The slave modport
// is the arbiter's view; master is the view of whatever drives it.
interface dma_cmd_arbiter_if;
  logic        req0_valid, req1_valid;
  logic [1:0]  req0_cmd, req1_cmd;
  logic [31:0] req0_address, req1_address;
  logic [7:0]  req0_burst_size, req1_burst_size;
  logic [7:0]  req0_block_size, req1_block_size;
  logic [3:0]  req0_byte_enable, req1_byte_enable;
  logic        req0_accept, req1_accept;
  logic        req0_done, req1_done;
  logic        req0_error, req1_error;
  logic [31:0] DMA_address;
  logic [7:0]  DMA_burst_size_OUT, DMA_block_size_OUT;
  logic [3:0]  DMA_byte_enable;
  logic        DMA_launch_read, DMA_launch_write, DMA_launch_simple_switch;
  logic        DMA_busy;
  logic [2:0]  arb_state;
  logic        last_grant;

  modport slave (
    input  req0_valid, req0_cmd, req0_address, req0_burst_size, req0_block_size, req0_byte_enable,
    input  req1_valid, req1_cmd, req1_address, req1_burst_size, req1_block_size, req1_byte_enable,
    input  DMA_busy,
    output req0_accept, req0_done, req0_error, req1_accept, req1_done, req1_error,
    output DMA_address, DMA_burst_size_OUT, DMA_block_size_OUT, DMA_byte_enable,
    output DMA_launch_read, DMA_launch_write, DMA_launch_simple_switch,
    output arb_state, last_grant
  );

  modport master (
    output req0_valid, req0_cmd, req0_address, req0_burst_size, req0_block_size, req0_byte_enable,
    output req1_valid, req1_cmd, req1_address, req1_burst_size, req1_block_size, req1_byte_enable,
    output DMA_busy,
    input  req0_accept, req0_done, req0_error, req1_accept, req1_done, req1_error,
    input  DMA_address, DMA_burst_size_OUT, DMA_block_size_OUT, DMA_byte_enable,
    input  DMA_launch_read, DMA_launch_write, DMA_launch_simple_switch,
    input  arb_state, last_grant
  );
endinterface

// File: rtl/dma_cmd_arbiter_rr.sv
// Two-way round-robin grant: on contention the requester that did not win
// last time goes first; a lone requester always wins.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       grant_vld,
  output logic       grant_idx
);
  assign grant_vld = |valid;
  assign grant_idx = (&valid) ? ~last_grant : valid[1];
endmodule

// File: rtl/dma_cmd_arbiter.sv
// Arbitrates two DMA command requesters onto one engine and tracks each
// command through launch, busy and completion. All outputs are registered.
module dma_cmd_arbiter
  import dma_arb_pkg::*;
#(
  parameter int BUSY_TIMEOUT = 16
) (
  input logic              system_clk,
  input logic              system_rstn,
  dma_cmd_arbiter_if.slave bus
);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e             state;
  logic [CNT_W-1:0]       cnt, cnt_inc;
  logic [NUM_REQ-1:0]     valid, accept, done, error;
  dma_req_t [NUM_REQ-1:0] req;
  dma_req_t               sel;
  logic [1:0]             cur_cmd;
  logic                   grant_vld, grant_idx, last_grant;
  logic                   launch_rd, launch_wr, launch_sw;

  assign valid  = {bus.req1_valid, bus.req0_valid};
  assign req[0] = '{bus.req0_cmd, bus.req0_address, bus.req0_burst_size,
                    bus.req0_block_size, bus.req0_byte_enable};
  assign req[1] = '{bus.req1_cmd, bus.req1_address, bus.req1_burst_size,
                    bus.req1_block_size, bus.req1_byte_enable};
  assign sel    = req[grant_idx];

  // Saturating increment; the counter parks at BUSY_TIMEOUT instead of wrapping.
  assign cnt_inc = (cnt == CNT_W'(BUSY_TIMEOUT)) ? cnt : cnt + CNT_W'(1);

  rr_arbiter2 u_rr (
    .valid     (valid),
    .last_grant(last_grant),
    .grant_vld (grant_vld),
    .grant_idx (grant_idx)
  );

  // Accept and launch are set on the capture edge so both pulse during LAUNCH;
  // done/error are set on the edge into DONE so they pulse during DONE.
  always_ff @(posedge system_clk) begin
    if (!system_rstn) begin
      state                  <= ST_IDLE;
      cnt                    <= '0;
      accept                 <= '0;
      done                   <= '0;
      error                  <= '0;
      launch_rd              <= 1'b0;
      launch_wr              <= 1'b0;
      launch_sw              <= 1'b0;
      cur_cmd                <= CMD_READ;
      last_grant             <= 1'b1;
      bus.DMA_address        <= '0;
      bus.DMA_burst_size_OUT <= '0;
      bus.DMA_block_size_OUT <= '0;
      bus.DMA_byte_enable    <= '0;
    end else begin
      accept    <= '0;
      done      <= '0;
      error     <= '0;
      launch_rd <= 1'b0;
      launch_wr <= 1'b0;
      launch_sw <= 1'b0;
      case (state)
        ST_IDLE: if (grant_vld) begin
          accept[grant_idx]      <= 1'b1;
          last_grant             <= grant_idx;
          cur_cmd                <= sel.cmd;
          bus.DMA_address        <= sel.address;
          bus.DMA_burst_size_OUT <= sel.burst_size;
          bus.DMA_block_size_OUT <= sel.block_size;
          bus.DMA_byte_enable    <= sel.byte_enable;
          launch_rd              <= (sel.cmd == CMD_READ);
          launch_wr              <= (sel.cmd == CMD_WRITE);
          launch_sw              <= (sel.cmd == CMD_SWITCH);
          state                  <= ST_LAUNCH;
        end
        ST_LAUNCH: begin
          cnt <= '0;
          if (cur_cmd == CMD_RSVD) begin
            done[last_grant]  <= 1'b1;
            error[last_grant] <= 1'b1;
            state             <= ST_DONE;
          end else begin
            state <= ST_WAIT_BUSY;
          end
        end
        ST_WAIT_BUSY: begin
          if (bus.DMA_busy) begin
            state <= ST_WAIT_IDLE;
          end else begin
            cnt <= cnt_inc;
            if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
              done[last_grant]  <= 1'b1;
              error[last_grant] <= 1'b1;
              state             <= ST_DONE;
            end
          end
        end
        ST_WAIT_IDLE: if (!bus.DMA_busy) begin
          done[last_grant] <= 1'b1;
          state            <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.req0_accept              = accept[0];
  assign bus.req1_accept              = accept[1];
  assign bus.req0_done                = done[0];
  assign bus.req1_done                = done[1];
  assign bus.req0_error               = error[0];
  assign bus.req1_error               = error[1];
  assign bus.DMA_launch_read          = launch_rd;
  assign bus.DMA_launch_write         = launch_wr;
  assign bus.DMA_launch_simple_switch = launch_sw;
  assign bus.arb_state                = state;
  assign bus.last_grant               = last_grant;

endmodule

// File: doc/dma_cmd_arbiter.md
DMA_CMD_ARBITER -- requirements
Module: dma_cmd_arbiter

Interface
REQ-001 Parameter BUSY_TIMEOUT, default 16: cycles allowed for DMA_busy to rise after a launch.
REQ-002 system_clk  input  1  sole clock; all logic on rising edge.
REQ-003 system_rstn  input  1  reset, synchronous, active-low.
REQ-004 reqN_valid (N=0,1)  input  1  requester N holds a command.
REQ-005 reqN_cmd  input  2  command: 00 READ, 01 WRITE, 10 SWITCH, 11 reserved.
REQ-006 reqN_address  input  32  DMA bus address.
REQ-007 reqN_burst_size  input  8  burst length.
REQ-008 reqN_block_size  input  8  block length.
REQ-009 reqN_byte_enable  input  4  byte lanes.
REQ-010 reqN_accept  output  1  one-cycle pulse; command N captured.
REQ-011 reqN_done  output  1  one-cycle pulse; command N finished.
REQ-012 reqN_error  output  1  valid with reqN_done; 1 = timeout or reserved cmd.
REQ-013 DMA_address, DMA_burst_size_OUT, DMA_block_size_OUT, DMA_byte_enable  output  32/8/8/4  registered command fields.
REQ-014 DMA_launch_read, DMA_launch_write, DMA_launch_simple_switch  output  1 each  one-cycle launch pulses.
REQ-015 DMA_busy  input  1  DMA engine active.
REQ-016 arb_state  output  3  current FSM state encoding, for status LEDs.
REQ-017 last_grant  output  1  index of most recently granted requester.

Function
REQ-018 FSM states: IDLE, LAUNCH, WAIT_BUSY, WAIT_IDLE, DONE.
REQ-019 IDLE: when any reqN_valid is high, grant round-robin (priority to requester != last_grant), pulse reqN_accept, latch all fields into DMA_* registers, update last_grant, go LAUNCH.
REQ-020 Both valid in the same cycle: grant the one not equal to last_grant; after reset last_grant=1, so requester 0 wins first.
REQ-021 LAUNCH (1 cycle): pulse exactly one launch output per latched cmd; go WAIT_BUSY; cmd 11 pulses nothing and goes DONE with error set.
REQ-022 WAIT_BUSY: DMA_busy high -> WAIT_IDLE; counter reaching BUSY_TIMEOUT with busy low -> DONE with error set.
REQ-023 WAIT_IDLE: DMA_busy low -> DONE; no timeout in this state.
REQ-024 DONE (1 cycle): pulse reqN_done (and reqN_error) for the granted requester, clear error flag, go IDLE.
REQ-025 Minimum turnaround accept-to-done with busy high one cycle: 4 cycles; next accept no earlier than the cycle after DONE.
REQ-026 reqN_valid changes outside IDLE are ignored; the latched command is unaffected.
REQ-027 Launch outputs never assert outside LAUNCH; at most one asserted per cycle.
REQ-028 Timeout counter clears on entry to WAIT_BUSY; width ceil(log2(BUSY_TIMEOUT+1)); saturates, no wrap.
REQ-029 DMA_* field outputs hold value until the next accept.

Reset
REQ-030 On system_rstn low at a clock edge: state IDLE, all pulses 0, DMA_* fields 0, error 0, counter 0, last_grant 1.
REQ-031 Reset mid-command abandons it; no reqN_done is generated for it.

Structure
REQ-032 Package dma_arb_pkg holds cmd encodings (CMD_READ/WRITE/SWITCH) and FSM state encodings.
REQ-033 One sub-module rr_arbiter2 (2-way round-robin, combinational grant from valids and last_grant).

Verification
REQ-034 req0 WRITE addr 0x0000_1000, busy high 3 cycles from LAUNCH+1 -> accept0, one DMA_launch_write pulse, DMA_address=0x1000, done0 with error=0.
REQ-035 req0 and req1 valid same cycle after reset -> req0 granted first, req1 granted in cycle after done0; last_grant 0 then 1.
REQ-036 req1 READ, busy never rises -> done1 with error1=1 exactly BUSY_TIMEOUT cycles after entering WAIT_BUSY; no further launch.
REQ-037 req0 cmd=11 -> no launch pulse, done0 with error0=1 two cycles after accept.
REQ-038 Reset asserted in WAIT_IDLE -> next cycle all outputs zero, state IDLE, no done pulse.
REQ-039 req1 SWITCH while req0 held valid -> alternation 1,0,1 over three commands; one DMA_launch_simple_switch per SWITCH.
